instruction_issue_unit: RTL and testbench

Sequencer that feeds the control signal generator: it fetches each instruction word from ROM with a request/valid handshake and holds it stable on `Instruction`. It then walks the five processor stages and updates the PC at the end of write-back. It is the supplying end of the `Instruction`/`Stage` interface that the control signal generator decodes. It replaces the free-running stage counter with a stall-aware FSM.

---
 rtl/instruction_issue_unit.sv | 115 +++++++++++
 tb/tb_instruction_issue_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_issue_unit.sv
// Stall-aware fetch/execute sequencer feeding the control signal generator.
// Fetches one word per instruction, walks the five stages, updates PC on retire.
module instruction_issue_unit #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Run,
  input  logic        Stall,
  output logic        ROM1_Read,
  output logic [31:0] ROM_Address,
  input  logic [31:0] ROM_Data,
  input  logic        ROM_Valid,
  input  logic        PC_Select,
  input  logic        INC_Select,
  input  logic [31:0] RA_Value,
  input  logic [31:0] Branch_Offset,
  output logic [31:0] Instruction,
  output logic        Instruction_Valid,
  output logic [2:0]  Stage,
  output logic [31:0] PC_Out,
  output logic [15:0] Instr_Count,
  output logic        Fetch_Error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_REQ,
    S_FETCH_WAIT,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  wait_cnt;
  logic [31:0] pc;
  logic [31:0] pc_inc;
  logic [31:0] pc_nxt;
  logic        fetch_hit;
  logic        fetch_timeout;
  logic        retire;

  assign fetch_hit     = (state == S_FETCH_WAIT) && ROM_Valid;
  assign fetch_timeout = (state == S_FETCH_WAIT) && !ROM_Valid
                      && (wait_cnt == WAIT_LAST);
  assign retire        = (state == S_WRITEBACK) && !Stall;

  assign pc_inc = INC_Select ? Branch_Offset : 32'd1;
  assign pc_nxt = PC_Select ? pc + pc_inc : RA_Value;

  always_ff @(posedge Clock) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:       if (Run) state_nxt = S_FETCH_REQ;
      S_FETCH_REQ:  state_nxt = S_FETCH_WAIT;
      S_FETCH_WAIT: begin
        if (fetch_hit)          state_nxt = S_DECODE;
        else if (fetch_timeout) state_nxt = S_FETCH_REQ;
      end
      S_DECODE:     if (!Stall) state_nxt = S_EXECUTE;
      S_EXECUTE:    if (!Stall) state_nxt = S_MEMORY;
      S_MEMORY:     if (!Stall) state_nxt = S_WRITEBACK;
      S_WRITEBACK:  if (!Stall) state_nxt = Run ? S_FETCH_REQ : S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    Stage = 3'd0;
    unique case (1'b1)
      state == S_DECODE:    Stage = 3'd1;
      state == S_EXECUTE:   Stage = 3'd2;
      state == S_MEMORY:    Stage = 3'd3;
      state == S_WRITEBACK: Stage = 3'd4;
      default:              Stage = 3'd0;
    endcase
  end

  assign ROM1_Read         = (state == S_FETCH_REQ);
  assign Instruction_Valid = (Stage != 3'd0);
  assign ROM_Address       = pc;
  assign PC_Out            = pc;

  // Counter is cleared in FETCH_REQ so every FETCH_WAIT entry starts at 0.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc          <= RESET_PC;
      Instruction <= 32'h0;
      Instr_Count <= 16'h0;
      Fetch_Error <= 1'b0;
      wait_cnt    <= 8'h0;
    end else begin
      if (state == S_FETCH_REQ)       wait_cnt <= 8'h0;
      else if (state == S_FETCH_WAIT) wait_cnt <= wait_cnt + 8'd1;
      if (fetch_hit)     Instruction <= ROM_Data;
      if (fetch_timeout) Fetch_Error <= 1'b1;
      if (retire) begin
        pc          <= pc_nxt;
        Instr_Count <= Instr_Count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_issue_unit.sv
// Bench for instruction_issue_unit: per-cycle reference model plus
// directed instruction scenarios with literal expectations.
module tb_instruction_issue_unit;
  localparam int TO = 4;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Run = 1'b0;
  logic        Stall = 1'b0;
  logic        ROM_Valid = 1'b0;
  logic [31:0] ROM_Data = 32'h0;
  logic        PC_Select = 1'b1;
  logic        INC_Select = 1'b0;
  logic [31:0] RA_Value = 32'h0;
  logic [31:0] Branch_Offset = 32'h0;
  logic        ROM1_Read;
  logic [31:0] ROM_Address;
  logic [31:0] Instruction;
  logic        Instruction_Valid;
  logic [2:0]  Stage;
  logic [31:0] PC_Out;
  logic [15:0] Instr_Count;
  logic        Fetch_Error;

  always #5 Clock = ~Clock;

  instruction_issue_unit #(
    .RESET_PC(32'h0),
    .TIMEOUT(TO)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Run(Run),
    .Stall(Stall),
    .ROM1_Read(ROM1_Read),
    .ROM_Address(ROM_Address),
    .ROM_Data(ROM_Data),
    .ROM_Valid(ROM_Valid),
    .PC_Select(PC_Select),
    .INC_Select(INC_Select),
    .RA_Value(RA_Value),
    .Branch_Offset(Branch_Offset),
    .Instruction(Instruction),
    .Instruction_Valid(Instruction_Valid),
    .Stage(Stage),
    .PC_Out(PC_Out),
    .Instr_Count(Instr_Count),
    .Fetch_Error(Fetch_Error)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ROM: answers each request after rom_lat cycles; rom_skip drops requests.
  int cd = 0;
  int rom_lat = 1;
  int rom_skip = 0;
  bit force_v = 1'b0;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'hA5A5_0001 : {16'hC0DE, a[15:0]};
  endfunction

  always @(negedge Clock) begin
    logic v;
    v = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        v = 1'b1;
        ROM_Data = rom_word(ROM_Address);
      end
    end
    if (ROM1_Read) begin
      if (rom_skip > 0) rom_skip--;
      else cd = rom_lat;
    end
    ROM_Valid = v | force_v;
  end

  // Reference model: stage number, pending request, waiting flag.
  bit          m_on = 1'b0;
  int          m_stage;
  bit          m_req;
  bit          m_waiting;
  int          m_wait;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  int          m_cnt;
  bit          m_err;

  always @(posedge Clock) begin
    if (Reset) begin
      m_on = 1'b1; m_stage = 0; m_req = 0; m_waiting = 0; m_wait = 0;
      m_pc = 32'h0; m_instr = 32'h0; m_cnt = 0; m_err = 0;
    end else if (m_on) begin
      if (m_stage > 0) begin
        if (!Stall) begin
          if (m_stage < 4) m_stage++;
          else begin
            m_cnt = (m_cnt + 1) % 65536;
            m_pc = PC_Select ? m_pc + (INC_Select ? Branch_Offset : 32'd1)
                             : RA_Value;
            m_stage = 0;
            m_req = Run;
          end
        end
      end else if (m_req) begin
        m_req = 0; m_waiting = 1; m_wait = 0;
      end else if (m_waiting) begin
        if (ROM_Valid) begin
          m_instr = ROM_Data; m_waiting = 0; m_stage = 1;
        end else begin
          m_wait++;
          if (m_wait == TO) begin
            m_err = 1; m_waiting = 0; m_req = 1;
          end
        end
      end else if (Run) m_req = 1;
    end
  end

  always @(negedge Clock) begin
    if (m_on) begin
      chk("stage", 32'(Stage), m_stage);
      chk("rom_read", 32'(ROM1_Read), 32'(m_req));
      chk("rom_addr", ROM_Address, m_pc);
      chk("pc_out", PC_Out, m_pc);
      chk("instr", Instruction, m_instr);
      chk("ivalid", 32'(Instruction_Valid), 32'(m_stage != 0));
      chk("count", 32'(Instr_Count), m_cnt);
      chk("ferr", 32'(Fetch_Error), 32'(m_err));
    end
  end

  int          period;
  int          nreq;
  logic [31:0] req_addr [2];
  int          stage_seq [32];
  int          seq_n;
  logic [31:0] ins_at_decode;
  bit          ins_changed;

  task automatic run_instr(input int stall_stage, input int stall_n,
                           input int run_off_stage);
    int   left;
    bit   done;
    logic [2:0] prev;
    period = 0; nreq = 0; seq_n = 0; ins_changed = 0;
    left = stall_n; done = 0; prev = 3'd0;
    for (int i = 0; i < 100 && !ROM1_Read; i++) @(negedge Clock);
    if (!ROM1_Read) begin
      checks++; failures++;
      $display("FAIL fetch_start: got no ROM1_Read expected a request");
      return;
    end
    for (int i = 0; i < 200; i++) begin
      if (prev == 3'd4 && Stage != 3'd4) begin
        done = 1;
        break;
      end
      period++;
      if (ROM1_Read) begin
        if (nreq < 2) req_addr[nreq] = ROM_Address;
        nreq++;
      end
      if (seq_n < 32) stage_seq[seq_n] = Stage;
      seq_n++;
      if (Stage == 3'd1 && prev != 3'd1) ins_at_decode = Instruction;
      if (Stage > 3'd1 && Instruction !== ins_at_decode) ins_changed = 1;
      Stall = (stall_stage != 0 && Stage == stall_stage && left > 0);
      if (Stall) left--;
      if (run_off_stage != 0 && Stage == run_off_stage) Run = 1'b0;
      prev = Stage;
      @(negedge Clock);
    end
    Stall = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL retire_timeout: got no retire expected one");
    end
  endtask

  initial begin
    int exp_seq [6] = '{0, 0, 1, 2, 3, 4};
    int n2;
    int extra;

    repeat (2) @(negedge Clock);
    chk("rst_stage", 32'(Stage), 0);
    chk("rst_addr", ROM_Address, 32'h0);
    chk("rst_instr", Instruction, 32'h0);
    chk("rst_ivalid", 32'(Instruction_Valid), 0);
    chk("rst_read", 32'(ROM1_Read), 0);
    chk("rst_count", 32'(Instr_Count), 0);
    chk("rst_ferr", 32'(Fetch_Error), 0);

    Reset = 1'b0; Run = 1'b1; PC_Select = 1'b1; INC_Select = 1'b0;
    run_instr(0, 0, 0);
    chk("t1_period", period, 6);
    for (int i = 0; i < 6; i++) chk("t1_stage_seq", stage_seq[i], exp_seq[i]);
    chk("t1_nreq", nreq, 1);
    chk("t1_req_addr", req_addr[0], 32'h0);
    chk("t1_instr", Instruction, 32'hA5A5_0001);
    chk("t1_pc", PC_Out, 32'h1);
    chk("t1_count", 32'(Instr_Count), 1);

    PC_Select = 1'b0; RA_Value = 32'd10;
    run_instr(0, 0, 0);
    chk("jump10_pc", PC_Out, 32'd10);

    PC_Select = 1'b1; INC_Select = 1'b1; Branch_Offset = 32'hFFFF_FFFC;
    run_instr(0, 0, 0);
    chk("branch_back_addr", ROM_Address, 32'd6);

    PC_Select = 1'b0; RA_Value = 32'hFFFF_FFFF;
    run_instr(0, 0, 0);
    chk("jump_top_pc", PC_Out, 32'hFFFF_FFFF);
    PC_Select = 1'b1; INC_Select = 1'b0;
    run_instr(0, 0, 0);
    chk("wrap_pc", ROM_Address, 32'h0);

    PC_Select = 1'b0; INC_Select = 1'b1; RA_Value = 32'h40;
    Branch_Offset = 32'd7;
    run_instr(0, 0, 0);
    chk("ra_addr", ROM_Address, 32'h40);

    PC_Select = 1'b1; INC_Select = 1'b0;
    run_instr(2, 3, 0);
    n2 = 0;
    for (int i = 0; i < seq_n && i < 32; i++) if (stage_seq[i] == 2) n2++;
    chk("stall_period", period, 9);
    chk("stall_exec_cycles", n2, 4);
    chk("stall_instr_held", 32'(ins_changed), 0);
    chk("stall_pc", PC_Out, 32'h41);

    rom_skip = 1;
    run_instr(0, 0, 0);
    chk("to_period", period, 11);
    chk("to_nreq", nreq, 2);
    chk("to_addr0", req_addr[0], 32'h41);
    chk("to_addr1", req_addr[1], 32'h41);
    chk("to_ferr", 32'(Fetch_Error), 1);
    chk("to_count", 32'(Instr_Count), 8);

    run_instr(0, 0, 2);
    chk("runoff_period", period, 6);
    chk("runoff_count", 32'(Instr_Count), 9);
    chk("runoff_pc", PC_Out, 32'h43);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      if (ROM1_Read) extra++;
      @(negedge Clock);
    end
    chk("runoff_no_read", extra, 0);
    chk("runoff_stage", 32'(Stage), 0);
    chk("ferr_sticky", 32'(Fetch_Error), 1);

    Run = 1'b1;
    for (int i = 0; i < 50 && Stage != 3'd3; i++) @(negedge Clock);
    chk("reach_memory", 32'(Stage), 3);
    Reset = 1'b1; Run = 1'b0;
    @(negedge Clock);
    Reset = 1'b0;
    chk("mrst_stage", 32'(Stage), 0);
    chk("mrst_pc", PC_Out, 32'h0);
    chk("mrst_instr", Instruction, 32'h0);
    chk("mrst_count", 32'(Instr_Count), 0);
    chk("mrst_ferr", 32'(Fetch_Error), 0);
    force_v = 1'b1;
    @(negedge Clock);
    force_v = 1'b0;
    repeat (2) @(negedge Clock);
    chk("late_valid_stage", 32'(Stage), 0);
    chk("late_valid_instr", Instruction, 32'h0);

    Run = 1'b1;
    for (int i = 0; i < 20 && !ROM1_Read; i++) @(negedge Clock);
    Reset = 1'b1; Run = 1'b0;
    @(negedge Clock);
    Reset = 1'b0;
    repeat (4) @(negedge Clock);
    chk("fetch_rst_instr", Instruction, 32'h0);
    chk("fetch_rst_ivalid", 32'(Instruction_Valid), 0);
    chk("fetch_rst_read", 32'(ROM1_Read), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
